// File: rtl/fifo_flowctl_if.sv
// Handshake/bus bundle for fifo_flowctl: push/pop requests, thresholds, data and status.
interface fifo_flowctl_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 4
);
  logic                 write;
  logic                 read;
  logic [DATA_SIZE-1:0] data_in_push;
  logic [ADDR_SIZE:0]   almost_full_in;
  logic [ADDR_SIZE:0]   almost_empty_in;
  logic [DATA_SIZE-1:0] data_out_pop;
  logic                 data_valid;
  logic [ADDR_SIZE:0]   data_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 fifo_pause;
  logic                 fifo_error;

  modport master (
    output write, read, data_in_push, almost_full_in, almost_empty_in,
    input  data_out_pop, data_valid, data_count, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_pause, fifo_error
  );

  modport slave (
    input  write, read, data_in_push, almost_full_in, almost_empty_in,
    output data_out_pop, data_valid, data_count, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_pause, fifo_error
  );
endinterface

// File: rtl/fifo_flowctl.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, pause and error flag.
// Optional macro FIFO_PAUSE_HYST_EN: registered fifo_pause with threshold hysteresis.
module fifo_flowctl #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 4
) (
  input logic           clk,
  input logic           reset,
  fifo_flowctl_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
  localparam int unsigned CNT_W = ADDR_SIZE + 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [DATA_SIZE-1:0] dout;
  logic                 valid;
  logic                 error;
  logic                 is_empty;
  logic                 is_full;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 error_next;

  // Request acceptance; a push into a full FIFO is allowed only alongside an accepted pop
  always_comb begin
    is_empty   = (count == '0);
    is_full    = (count == CNT_W'(DEPTH));
    pop_ok     = bus.read && !is_empty;
    push_ok    = bus.write && (!is_full || pop_ok);
    error_next = (bus.write && !push_ok) || (bus.read && !pop_ok);
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + CNT_W'(1);
    else if (pop_ok && !push_ok)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
      error  <= 1'b0;
    end else begin
      count <= count_next;
      valid <= pop_ok;
      error <= error_next;
      if (push_ok)
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
        dout   <= mem[rd_ptr];
      end
    end
  end

  // Storage is not reset; pointers alone define valid contents
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= bus.data_in_push;
  end

  assign bus.data_out_pop = dout;
  assign bus.data_valid   = valid;
  assign bus.data_count   = count;
  assign bus.fifo_empty   = is_empty;
  assign bus.fifo_full    = is_full;
  assign bus.fifo_error   = error;
  assign bus.almost_full  = (count >= bus.almost_full_in);
  assign bus.almost_empty = (count <= bus.almost_empty_in) && !is_empty;

`ifdef FIFO_PAUSE_HYST_EN
  logic pause;

  // Hysteresis judged on the post-update count so pause moves on the same edge as data_count
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pause <= 1'b0;
    else if (count_next >= bus.almost_full_in)
      pause <= 1'b1;
    else if (count_next <= bus.almost_empty_in)
      pause <= 1'b0;
  end

  assign bus.fifo_pause = pause;
`else
  assign bus.fifo_pause = bus.almost_full;
`endif

endmodule

// File: tb/tb_fifo_flowctl.sv
// Directed table-driven bench for fifo_flowctl (DEPTH=16) plus hand-written corner sequences.
module tb_fifo_flowctl;

`ifdef FIFO_PAUSE_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fifo_flowctl_if #(.DATA_SIZE(8), .ADDR_SIZE(4)) bus ();

  fifo_flowctl #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [4:0] af;
    logic [4:0] ae;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       afl;
    logic       ael;
    logic       vld;
    logic [7:0] dout;
    logic       err;
    logic       ph;
    logic       pn;
  } vec_t;

  function automatic vec_t mk(int w, int r, int d, int af, int ae, int cnt, int emp, int ful,
                              int afl, int ael, int vld, int dout, int err, int ph, int pn);
    vec_t v;
    v.w = 1'(w);   v.r = 1'(r);     v.d = 8'(d);     v.af = 5'(af);   v.ae = 5'(ae);
    v.cnt = 5'(cnt); v.emp = 1'(emp); v.ful = 1'(ful); v.afl = 1'(afl); v.ael = 1'(ael);
    v.vld = 1'(vld); v.dout = 8'(dout); v.err = 1'(err); v.ph = 1'(ph); v.pn = 1'(pn);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests at negedge, return 1ns after the following posedge
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    bus.write        = w;
    bus.read         = r;
    bus.data_in_push = d;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.write           = 1'b0;
    bus.read            = 1'b0;
    bus.data_in_push    = 8'h00;
    bus.almost_full_in  = 5'd12;
    bus.almost_empty_in = 5'd3;
    reset               = 1'b1;

    //             w r  d    af ae cnt emp ful afl ael vld dout err ph pn
    tbl[0] = mk(0, 1, 8'h00, 3, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[1] = mk(1, 1, 8'hA5, 3, 1, 1, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0);
    tbl[2] = mk(1, 0, 8'h3C, 3, 1, 2, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[3] = mk(1, 0, 8'h7E, 3, 1, 3, 0, 0, 1, 0, 0, 8'h00, 0, 1, 1);
    tbl[4] = mk(0, 1, 8'h00, 3, 1, 2, 0, 0, 0, 0, 1, 8'hA5, 0, 1, 0);
    tbl[5] = mk(1, 1, 8'h11, 3, 1, 2, 0, 0, 0, 0, 1, 8'h3C, 0, 1, 0);
    tbl[6] = mk(0, 0, 8'h00, 2, 1, 2, 0, 0, 1, 0, 0, 8'h3C, 0, 1, 1);
    tbl[7] = mk(0, 1, 8'h00, 3, 1, 1, 0, 0, 0, 1, 1, 8'h7E, 0, 0, 0);
    tbl[8] = mk(0, 1, 8'h00, 3, 1, 0, 1, 0, 0, 0, 1, 8'h11, 0, 0, 0);
    tbl[9] = mk(0, 0, 8'h00, 3, 1, 0, 1, 0, 0, 0, 0, 8'h11, 0, 0, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", 32'({bus.data_count, bus.fifo_empty, bus.fifo_full, bus.almost_full,
                              bus.almost_empty, bus.data_valid, bus.data_out_pop, bus.fifo_error,
                              bus.fifo_pause}),
          32'({5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h81 + i));
    step(1'b0, 1'b1, 8'h00);
    check("t1_pop_before_reset", 32'({bus.data_valid, bus.data_out_pop}), 32'({1'b1, 8'h81}));
    #2;
    reset = 1'b1;
    #1;
    check("t1_async_reset", 32'({bus.data_count, bus.fifo_empty, bus.data_valid, bus.data_out_pop}),
          32'({5'd0, 1'b1, 1'b0, 8'h00}));
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors, including same-cycle threshold changes
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.almost_full_in  = tbl[i].af;
      bus.almost_empty_in = tbl[i].ae;
      step(tbl[i].w, tbl[i].r, tbl[i].d);
      check($sformatf("vec%0d", i),
            32'({bus.data_count, bus.fifo_empty, bus.fifo_full, bus.almost_full, bus.almost_empty,
                 bus.data_valid, bus.data_out_pop, bus.fifo_error, bus.fifo_pause}),
            32'({tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].afl, tbl[i].ael, tbl[i].vld,
                 tbl[i].dout, tbl[i].err, (HYST ? tbl[i].ph : tbl[i].pn)}));
    end
    bus.almost_full_in  = 5'd12;
    bus.almost_empty_in = 5'd3;

    // Fill to full, then drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check($sformatf("t2_count%0d", i), 32'(bus.data_count), 32'(i + 1));
    end
    check("t2_full", 32'({bus.fifo_full, bus.almost_full, bus.fifo_error}), 32'({1'b1, 1'b1, 1'b0}));
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("t2_pop%0d", i), 32'({bus.data_valid, bus.data_out_pop}), 32'({1'b1, 8'(i)}));
    end
    check("t2_empty", 32'({bus.fifo_empty, bus.data_count}), 32'({1'b1, 5'd0}));

    // Full FIFO with simultaneous push and pop: count stays, pointers wrap
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h30 + i));
      check($sformatf("t3_cycle%0d", i),
            32'({bus.data_count, bus.fifo_error, bus.data_valid, bus.data_out_pop}),
            32'({5'd16, 1'b0, 1'b1, (i < 16) ? 8'(8'h20 + i) : 8'(8'h30 + i - 16)}));
    end

    // Rejected push when full, then rejected pop when empty
    step(1'b1, 1'b0, 8'hEE);
    check("t4_push_full", 32'({bus.fifo_error, bus.data_count, bus.fifo_full}), 32'({1'b1, 5'd16, 1'b1}));
    step(1'b0, 1'b0, 8'h00);
    check("t4_err_clear", 32'({bus.fifo_error, bus.data_count}), 32'({1'b0, 5'd16}));
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("t4_drain%0d", i), 32'({bus.data_valid, bus.data_out_pop}),
            32'({1'b1, 8'(8'h34 + i)}));
    end
    step(1'b0, 1'b1, 8'h00);
    check("t4_pop_empty", 32'({bus.fifo_error, bus.data_valid, bus.data_count, bus.data_out_pop}),
          32'({1'b1, 1'b0, 5'd0, 8'h43}));
    step(1'b0, 1'b0, 8'h00);
    check("t4_err_pulse", 32'(bus.fifo_error), 32'd0);

    // Threshold and pause behaviour
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'(8'h50 + i));
      if (i == 10)
        check("t5_count11", 32'({bus.almost_full, bus.fifo_pause}), 32'({1'b0, 1'b0}));
    end
    check("t5_fill12", 32'({bus.data_count, bus.almost_full, bus.fifo_pause}),
          32'({5'd12, 1'b1, 1'b1}));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
    check("t5_drain8", 32'({bus.data_count, bus.almost_full, bus.almost_empty, bus.fifo_pause}),
          32'({5'd8, 1'b0, 1'b0, HYST}));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    check("t5_drain3", 32'({bus.data_count, bus.almost_empty, bus.fifo_pause, bus.data_out_pop}),
          32'({5'd3, 1'b1, 1'b0, 8'h58}));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    check("t5_empty", 32'({bus.fifo_empty, bus.almost_empty, bus.data_out_pop}),
          32'({1'b1, 1'b0, 8'h5B}));

    // Push and pop together on an empty FIFO: no fall-through
    step(1'b1, 1'b1, 8'h9C);
    check("t6_both_empty",
          32'({bus.data_count, bus.data_valid, bus.fifo_error, bus.fifo_empty, bus.data_out_pop}),
          32'({5'd1, 1'b0, 1'b1, 1'b0, 8'h5B}));
    step(1'b0, 1'b1, 8'h00);
    check("t6_read_back", 32'({bus.data_count, bus.data_valid, bus.fifo_error, bus.data_out_pop}),
          32'({5'd0, 1'b1, 1'b0, 8'h9C}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
